// File: rtl/sync_debounce_pkg.sv
// Shared helpers for the input conditioner: sizing of the per-bit debounce counter.
package sync_debounce_pkg;

    // Width of a counter able to hold 0 .. cycles; a bypassed debouncer still
    // gets a legal 1-bit width so no zero-width vectors are ever declared.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sync_debounce_bit.sv
// Single-bit debouncer: stable level plus registered one-cycle rise/fall strobes.
// The level only moves after DEBOUNCE_CYCLES consecutive mismatching clocks;
// any match in between throws the partial count away.
module debounce_bit
    import sync_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_bit,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic stable_q, stable_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        // No filtering: the level tracks the synchronised input every clock.
        always_comb stable_d = sync_bit;
    end else begin : g_count
        localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Count consecutive mismatches; flip the level on the terminal count.
        // The counter is cleared on flip and on match, so it can never pass TERM.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (sync_bit != stable_q) begin
                if (cnt_q == TERM) begin
                    stable_d = sync_bit;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Mismatch counter register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Edge strobes are decoded from the level update so they land with it.
    always_comb begin
        rise_d = stable_d & ~stable_q;
        fall_d = ~stable_d & stable_q;
    end

    // Level and strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= RESET_BIT;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-bit pin conditioner: SYNC_STAGES-deep synchroniser followed by an
// independent debouncer per bit, with per-bit edge strobes and a change flag.
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH           = 16,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("sync_debounce: SYNC_STAGES must be at least 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_debounce: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // Synchroniser chain; every stage resets to the configured idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= async_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[i])
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .sync_bit (sync_q[SYNC_STAGES-1][i]),
            .stable   (stable_out[i]),
            .rise     (rise_pulse[i]),
            .fall     (fall_pulse[i])
        );
    end

    // Reduction of the registered strobes, so it is high in exactly their cycle.
    assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: directed scenarios plus randomized pin activity
// compared against a window-based reference model of the debounce rule.
module tb_sync_debounce;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] async_in = 4'h0;

    logic [3:0] sync_a, stable_a, rise_a, fall_a;
    logic       any_a;
    logic [3:0] sync_b, stable_b, rise_b, fall_b;
    logic       any_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_debounce #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(4'h0)
    ) dut_a (
        .clk(clk), .reset(reset), .async_in(async_in),
        .sync_out(sync_a), .stable_out(stable_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
    );

    sync_debounce #(
        .WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .RESET_VALUE(4'h0)
    ) dut_b (
        .clk(clk), .reset(reset), .async_in(async_in),
        .sync_out(sync_b), .stable_out(stable_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b)
    );

    // Reference model. Sync view = input sampled SYNC_STAGES edges ago.
    // Debounce rule: a bit's level flips when each of the last DEBOUNCE_CYCLES
    // synchronised samples since reset differs from the current level.
    logic [3:0] aq_a[$];
    logic [3:0] win_a[$];
    logic [3:0] mst_a, mrise_a, mfall_a;
    logic       mchg_a;
    logic [3:0] aq_b[$];
    logic [3:0] mst_b, mrise_b, mfall_b;
    logic       mchg_b;

    task automatic model_reset();
        aq_a.delete();
        for (int k = 0; k < 2; k++) aq_a.push_back(4'h0);
        win_a.delete();
        mst_a = 4'h0; mrise_a = 4'h0; mfall_a = 4'h0; mchg_a = 1'b0;
        aq_b.delete();
        for (int k = 0; k < 3; k++) aq_b.push_back(4'h0);
        mst_b = 4'h0; mrise_b = 4'h0; mfall_b = 4'h0; mchg_b = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] pre, nxt;
        logic       flip;
        pre = aq_a[0];
        void'(aq_a.pop_front());
        aq_a.push_back(async_in);
        win_a.push_back(pre);
        if (win_a.size() > 4) void'(win_a.pop_front());
        nxt = mst_a;
        if (win_a.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                flip = 1'b1;
                foreach (win_a[k]) if (win_a[k][i] == mst_a[i]) flip = 1'b0;
                if (flip) nxt[i] = ~mst_a[i];
            end
        end
        mrise_a = nxt & ~mst_a;
        mfall_a = ~nxt & mst_a;
        mchg_a  = (nxt != mst_a);
        mst_a   = nxt;

        pre = aq_b[0];
        void'(aq_b.pop_front());
        aq_b.push_back(async_in);
        mrise_b = pre & ~mst_b;
        mfall_b = ~pre & mst_b;
        mchg_b  = (pre != mst_b);
        mst_b   = pre;
    endtask

    // One clock: model follows the edge, returns at the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        async_in = 4'hF;
        tick();
        tick();
        n_checks++;
        if ({sync_a, stable_a, rise_a, fall_a, any_a} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 0", {sync_a, stable_a, rise_a, fall_a, any_a});
        end
        n_checks++;
        if ({sync_b, stable_b, rise_b, fall_b, any_b} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 0", {sync_b, stable_b, rise_b, fall_b, any_b});
        end
    endtask

    task automatic test_first_rise();
        logic [3:0] es, est, er;
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            es  = (c >= 2) ? 4'hF : 4'h0;
            est = (c >= 6) ? 4'hF : 4'h0;
            er  = (c == 6) ? 4'hF : 4'h0;
            n_checks++;
            if ({sync_a, stable_a, rise_a, fall_a, any_a} !== {es, est, er, 4'h0, c == 6}) begin
                n_fail++;
                $display("FAIL first_rise clk %0d: got %h expected %h", c,
                         {sync_a, stable_a, rise_a, fall_a, any_a}, {es, est, er, 4'h0, c == 6});
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] est, ef;
        for (int k = 0; k < 20; k++) begin
            async_in[0] = (k < 10) ? (k % 2 == 1) : 1'b0;
            tick();
            est = (k + 1 < 16) ? 4'hF : 4'hE;
            ef  = (k + 1 == 16) ? 4'h1 : 4'h0;
            n_checks++;
            if ({stable_a, rise_a, fall_a, any_a} !== {est, 4'h0, ef, k + 1 == 16}) begin
                n_fail++;
                $display("FAIL bounce clk %0d: got %h expected %h", k + 1,
                         {stable_a, rise_a, fall_a, any_a}, {est, 4'h0, ef, k + 1 == 16});
            end
        end
    endtask

    task automatic test_partial_credit();
        logic [3:0] est, ef;
        for (int k = 0; k < 14; k++) begin
            async_in[1] = (k == 3);
            tick();
            est = (k + 1 < 10) ? 4'hE : 4'hC;
            ef  = (k + 1 == 10) ? 4'h2 : 4'h0;
            n_checks++;
            if ({stable_a, rise_a, fall_a, any_a} !== {est, 4'h0, ef, k + 1 == 10}) begin
                n_fail++;
                $display("FAIL partial_credit clk %0d: got %h expected %h", k + 1,
                         {stable_a, rise_a, fall_a, any_a}, {est, 4'h0, ef, k + 1 == 10});
            end
        end
    endtask

    task automatic test_opposite_edges();
        logic [3:0] est, er, ef;
        async_in = 4'h8;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (stable_a !== 4'h8) begin
            n_fail++;
            $display("FAIL opposite_setup: got %h expected 8", stable_a);
        end
        async_in = 4'h4;
        for (int c = 1; c <= 8; c++) begin
            tick();
            est = (c >= 6) ? 4'h4 : 4'h8;
            er  = (c == 6) ? 4'h4 : 4'h0;
            ef  = (c == 6) ? 4'h8 : 4'h0;
            n_checks++;
            if ({stable_a, rise_a, fall_a, any_a} !== {est, er, ef, c == 6}) begin
                n_fail++;
                $display("FAIL opposite clk %0d: got %h expected %h", c,
                         {stable_a, rise_a, fall_a, any_a}, {est, er, ef, c == 6});
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [3:0] est, er;
        async_in = 4'h5;
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if (stable_a !== 4'h4) begin
            n_fail++;
            $display("FAIL mid_pre_reset: got %h expected 4", stable_a);
        end
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({sync_a, stable_a, rise_a, fall_a, any_a} !== 17'h0) begin
            n_fail++;
            $display("FAIL mid_async_reset: got %h expected 0", {sync_a, stable_a, rise_a, fall_a, any_a});
        end
        tick();
        tick();
        reset = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            est = (c >= 6) ? 4'h5 : 4'h0;
            er  = (c == 6) ? 4'h5 : 4'h0;
            n_checks++;
            if ({stable_a, rise_a, fall_a, any_a} !== {est, er, 4'h0, c == 6}) begin
                n_fail++;
                $display("FAIL mid_recount clk %0d: got %h expected %h", c,
                         {stable_a, rise_a, fall_a, any_a}, {est, er, 4'h0, c == 6});
            end
        end
    endtask

    task automatic test_bypass();
        logic [3:0] vals[4];
        logic [3:0] prev;
        vals[0] = 4'hA; vals[1] = 4'h5; vals[2] = 4'hF; vals[3] = 4'h0;
        prev = async_in;
        for (int v = 0; v < 4; v++) begin
            async_in = vals[v];
            for (int c = 1; c <= 5; c++) begin
                tick();
                if (c == 3) begin
                    n_checks++;
                    if ({sync_b, stable_b} !== {vals[v], prev}) begin
                        n_fail++;
                        $display("FAIL bypass_early val %h: got %h expected %h", vals[v],
                                 {sync_b, stable_b}, {vals[v], prev});
                    end
                end else if (c == 4) begin
                    n_checks++;
                    if ({stable_b, rise_b, fall_b, any_b} !==
                        {vals[v], vals[v] & ~prev, ~vals[v] & prev, vals[v] != prev}) begin
                        n_fail++;
                        $display("FAIL bypass_edge val %h: got %h expected %h", vals[v],
                                 {stable_b, rise_b, fall_b, any_b},
                                 {vals[v], vals[v] & ~prev, ~vals[v] & prev, vals[v] != prev});
                    end
                end else if (c == 5) begin
                    n_checks++;
                    if ({rise_b, fall_b, any_b} !== 9'h0) begin
                        n_fail++;
                        $display("FAIL bypass_pulse_width val %h: got %h expected 0", vals[v],
                                 {rise_b, fall_b, any_b});
                    end
                end
            end
            prev = vals[v];
        end
    endtask

    task automatic test_random();
        int hold[4];
        for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 7);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) reset = 1'b1;
            if (cyc == 303) reset = 1'b0;
            for (int i = 0; i < 4; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    async_in[i] = ~async_in[i];
                    hold[i] = $urandom_range(1, 7);
                end
            end
            tick();
            n_checks++;
            if ({sync_a, stable_a, rise_a, fall_a, any_a} !==
                {aq_a[0], mst_a, mrise_a, mfall_a, mchg_a}) begin
                n_fail++;
                $display("FAIL random_a cyc %0d: got %h expected %h", cyc,
                         {sync_a, stable_a, rise_a, fall_a, any_a},
                         {aq_a[0], mst_a, mrise_a, mfall_a, mchg_a});
            end
            n_checks++;
            if ({sync_b, stable_b, rise_b, fall_b, any_b} !==
                {aq_b[0], mst_b, mrise_b, mfall_b, mchg_b}) begin
                n_fail++;
                $display("FAIL random_b cyc %0d: got %h expected %h", cyc,
                         {sync_b, stable_b, rise_b, fall_b, any_b},
                         {aq_b[0], mst_b, mrise_b, mfall_b, mchg_b});
            end
            n_checks++;
            if (((rise_a & fall_a) | (rise_b & fall_b)) !== 4'h0) begin
                n_fail++;
                $display("FAIL random_rise_and_fall cyc %0d: got %h expected 0", cyc,
                         (rise_a & fall_a) | (rise_b & fall_b));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_rise();
        test_bounce();
        test_partial_credit();
        test_opposite_edges();
        test_reset_mid_debounce();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
